// File: rtl/register_writeback_queue.sv
// register_writeback_queue
//   Collects register-file writes from the ALU and load paths into a small FIFO
//   and issues them one per cycle on the register file's single write port.
//   While writes wait in the queue or sit in the output stage, it also supplies
//   forwarding data so operand reads see values that are not yet committed.
//
//   Optional feature macro: WB_FORWARD_EN
//     defined   -> forwarding comparators and mux are built
//     undefined -> rsHit/rtHit/rsForward/rtForward are tied to 0
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   aluValid/aluAddress/aluData   ALU writeback request
//   memValid/memAddress/memData   load writeback request (older when both valid)
//   wbReady                       room for two requests this cycle
//   registerWrite/writeAddress/writeData  registered register-file write port
//   rsAddress/rtAddress           operand addresses being read
//   rsHit/rtHit, rsForward/rtForward      youngest pending write for each operand
//   pendingCount                  queued entries, not counting the output stage
//   idle                          queue empty and no write in flight
module register_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aluValid,
  input  logic [ADDR_WIDTH-1:0]    aluAddress,
  input  logic [DATA_WIDTH-1:0]    aluData,
  input  logic                     memValid,
  input  logic [ADDR_WIDTH-1:0]    memAddress,
  input  logic [DATA_WIDTH-1:0]    memData,
  output logic                     wbReady,
  output logic                     registerWrite,
  output logic [ADDR_WIDTH-1:0]    writeAddress,
  output logic [DATA_WIDTH-1:0]    writeData,
  input  logic [ADDR_WIDTH-1:0]    rsAddress,
  input  logic [ADDR_WIDTH-1:0]    rtAddress,
  output logic                     rsHit,
  output logic                     rtHit,
  output logic [DATA_WIDTH-1:0]    rsForward,
  output logic [DATA_WIDTH-1:0]    rtForward,
  output logic [$clog2(DEPTH):0]   pendingCount,
  output logic                     idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] qaddr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] qdata_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CW-1:0] count_q, count_d;
  logic          wr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic          push_mem, push_alu, pop;
  logic [1:0]    n_push;

  // Readiness looks only at the registered count, so it is stable all cycle.
  assign wbReady = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    // Writes to r0 are architecturally void; requests while not ready are dropped.
    push_mem = memValid && (memAddress != '0) && wbReady;
    push_alu = aluValid && (aluAddress != '0) && wbReady;
    pop      = (count_q != '0);
    n_push   = {1'b0, push_mem} + {1'b0, push_alu};
    // The mem entry is older, so the ALU entry lands one slot behind it.
    alu_slot = tail_q + PW'(push_mem);
    tail_d   = tail_q + PW'(n_push);
    head_d   = head_q + PW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
  end

  // Storage needs no reset: only entries inside head..count are ever observed.
  always_ff @(posedge clk) begin
    if (push_mem) begin
      qaddr_q[tail_q] <= memAddress;
      qdata_q[tail_q] <= memData;
    end
    if (push_alu) begin
      qaddr_q[alu_slot] <= aluAddress;
      qdata_q[alu_slot] <= aluData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= pop;
      if (pop) begin
        waddr_q <= qaddr_q[head_q];
        wdata_q <= qdata_q[head_q];
      end
    end
  end

  assign registerWrite = wr_q;
  assign writeAddress  = waddr_q;
  assign writeData     = wdata_q;
  assign pendingCount  = count_q;
  assign idle          = (count_q == '0) && !wr_q;

`ifdef WB_FORWARD_EN
  // Lane 0 serves rs, lane 1 serves rt.
  logic [1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]                 hit;
  logic [1:0][DATA_WIDTH-1:0] fwd;
  assign rd_addr = {rtAddress, rsAddress};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic                  l_hit;
    logic [DATA_WIDTH-1:0] l_fwd;
    logic [PW-1:0]         idx;
    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
      l_hit = 1'b0;
      l_fwd = '0;
      idx   = '0;
      if (wr_q && (waddr_q == rd_addr[g])) begin
        l_hit = 1'b1;
        l_fwd = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (qaddr_q[idx] == rd_addr[g])) begin
          l_hit = 1'b1;
          l_fwd = qdata_q[idx];
        end
      end
      if (rd_addr[g] == '0) begin
        l_hit = 1'b0;
        l_fwd = '0;
      end
    end
    assign hit[g] = l_hit;
    assign fwd[g] = l_fwd;
  end

  assign rsHit     = hit[0];
  assign rtHit     = hit[1];
  assign rsForward = fwd[0];
  assign rtForward = fwd[1];
`else
  logic unused_rd;
  assign unused_rd = ^{rsAddress, rtAddress};
  assign rsHit     = 1'b0;
  assign rtHit     = 1'b0;
  assign rsForward = '0;
  assign rtForward = '0;
`endif

`ifndef SYNTHESIS
  // Presenting a request while not ready is a producer bug.
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
    (aluValid || memValid) |-> wbReady);
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
module tb_register_writeback_queue;
  localparam bit FWD =
`ifdef WB_FORWARD_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aluValid = 1'b0, memValid = 1'b0;
  logic [4:0]  aluAddress = '0, memAddress = '0;
  logic [31:0] aluData = '0, memData = '0;
  logic        wbReady, registerWrite, rsHit, rtHit, idle;
  logic [4:0]  writeAddress;
  logic [31:0] writeData, rsForward, rtForward;
  logic [4:0]  rsAddress = '0, rtAddress = '0;
  logic [2:0]  pendingCount;

  register_writeback_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluAddress(aluAddress), .aluData(aluData),
    .memValid(memValid), .memAddress(memAddress), .memData(memData),
    .wbReady(wbReady), .registerWrite(registerWrite),
    .writeAddress(writeAddress), .writeData(writeData),
    .rsAddress(rsAddress), .rtAddress(rtAddress),
    .rsHit(rsHit), .rtHit(rtHit), .rsForward(rsForward), .rtForward(rtForward),
    .pendingCount(pendingCount), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one request pair for a single edge; expected writes queued mem first.
  task automatic issue(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    memValid = mv; memAddress = ma; memData = md;
    aluValid = av; aluAddress = aa; aluData = ad;
    if (mv && ma != 0) sb.push_back('{ma, md});
    if (av && aa != 0) sb.push_back('{aa, ad});
    step();
    memValid = 1'b0; aluValid = 1'b0;
  endtask

  // Monitor: every issued write must appear, in order, with the right payload.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && registerWrite) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", {27'd0, writeAddress}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", {27'd0, writeAddress}, {27'd0, e.a});
          chk("wr_data", writeData, e.d);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_regwrite", registerWrite, 0);
    chk("rst_waddr", writeAddress, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_count", pendingCount, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", wbReady, 1);
    @(negedge clk); rst = 1'b1;
    step();

    // Single ALU write to r12; same-cycle request is not forwarded
    rsAddress = 12;
    aluValid = 1'b1; aluAddress = 12; aluData = 1234;
    sb.push_back('{5'd12, 32'd1234});
    #1;
    chk("t1_no_sameCycle_hit", rsHit, 0);
    @(posedge clk); #1;
    aluValid = 1'b0;
    chk("t1_count1", pendingCount, 1);
    chk("t1_regwrite0", registerWrite, 0);
    chk("t1_hit_q", rsHit, FWD);
    chk("t1_fwd_q", rsForward, FWD ? 1234 : 0);
    step();
    chk("t1_regwrite1", registerWrite, 1);
    chk("t1_count0", pendingCount, 0);
    chk("t1_hit_out", rsHit, FWD);
    chk("t1_notidle", idle, 0);
    step();
    chk("t1_regwrite_off", registerWrite, 0);
    chk("t1_hit_gone", rsHit, 0);
    chk("t1_idle", idle, 1);

    // Paired mem r5 and ALU r12: drained 5 then 12
    rtAddress = 5;
    issue(1'b1, 5'd5, 32'(-555555), 1'b1, 5'd12, 32'd1234);
    chk("t2_count2", pendingCount, 2);
    chk("t2_rt_hit", rtHit, FWD);
    chk("t2_rt_fwd", rtForward, FWD ? 32'(-555555) : 0);
    step();
    chk("t2_count1", pendingCount, 1);
    chk("t2_first5", writeAddress, 5);
    step();
    chk("t2_count0", pendingCount, 0);
    chk("t2_second12", writeAddress, 12);
    step();
    chk("t2_idle", idle, 1);

    // Write to r0 is dropped
    rtAddress = 0;
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd1234);
    chk("t3_count0", pendingCount, 0);
    chk("t3_regwrite0", registerWrite, 0);
    chk("t3_rt_nohit", rtHit, 0);
    step();
    chk("t3_regwrite_still0", registerWrite, 0);
    chk("t3_idle", idle, 1);

    // r7 written 1 then 2: youngest forwards, drain in order
    rsAddress = 7;
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd1);
    chk("t4_fwd1", rsForward, FWD ? 1 : 0);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2);
    chk("t4_count1", pendingCount, 1);
    chk("t4_out1", writeData, 1);
    chk("t4_fwd_young", rsForward, FWD ? 2 : 0);
    step();
    chk("t4_out2", writeData, 2);
    chk("t4_hit_out", rsHit, FWD);
    chk("t4_fwd_out", rsForward, FWD ? 2 : 0);
    step();
    chk("t4_hit_gone", rsHit, 0);
    chk("t4_idle", idle, 1);

    // Fill with pairs: 10 writes wrap the 4-entry ring
    for (int p = 0; p < 5; p++) begin
      issue(1'b1, 5'(1 + 2*p), 32'h100 + 32'(2*p), 1'b1, 5'(2 + 2*p), 32'h101 + 32'(2*p));
      chk("t5_count_pair", pendingCount, (p == 0) ? 2 : 3);
      chk("t5_ready_pair", wbReady, (p == 0) ? 1 : 0);
      if (p != 0) begin
        step();
        chk("t5_count_gap", pendingCount, 2);
        chk("t5_ready_gap", wbReady, 1);
      end
    end
    for (int i = 0; i < 10 && !idle; i++) step();
    chk("t5_drained_idle", idle, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // Reset with 3 entries pending: immediate reset outputs, nothing replayed
    issue(1'b1, 5'd20, 32'hA0, 1'b1, 5'd21, 32'hA1);
    issue(1'b1, 5'd22, 32'hA2, 1'b1, 5'd23, 32'hA3);
    chk("t6_count3", pendingCount, 3);
    rst = 1'b0;
    #1;
    chk("t6_regwrite0", registerWrite, 0);
    chk("t6_waddr0", writeAddress, 0);
    chk("t6_wdata0", writeData, 0);
    chk("t6_count0", pendingCount, 0);
    chk("t6_idle", idle, 1);
    chk("t6_ready", wbReady, 1);
    sb.delete();
    @(negedge clk); rst = 1'b1;
    repeat (6) step();
    chk("t6_no_stale", registerWrite, 0);
    chk("t6_idle_after", idle, 1);
    chk("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
